pixel_gather: RTL and testbench

PIXEL_GATHER -- requirements
Module: pixel_gather

---
 rtl/pixel_gather_if.sv | 22 ++
 rtl/pixel_gather.sv | 137 +++++++++++++
 tb/tb_pixel_gather.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_gather_if.sv
// Request/VRAM/pixel bundle between a requester and the pixel_gather tap fetcher.
// The requester owns start, bypass and the VRAM read data; the gatherer owns the rest.
interface pixel_gather_if;
    logic        start;
    logic        bypass;
    logic [23:0] vramData;
    logic [2:0]  addrCount;
    logic [23:0] pixel;
    logic        pixelValid;
    logic        busy;
    logic        overrun;

    modport master (
        output start, bypass, vramData,
        input  addrCount, pixel, pixelValid, busy, overrun
    );

    modport slave (
        input  start, bypass, vramData,
        output addrCount, pixel, pixelValid, busy, overrun
    );
endinterface

// File: rtl/pixel_gather.sv
// Fetches four VRAM taps (A..D) per request and emits either their per-channel
// average or tap A alone, with a fixed start-to-pixel latency of 5+READ_LAT cycles.
module pixel_gather #(
    parameter int READ_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pixel_gather_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_e;

    state_e              state_q;
    logic [2:0]          addrCount_q;
    logic [23:0]         pixel_q;
    logic [23:0]         tap0_q;
    logic                pixelValid_q;
    logic                busy_q;
    logic                overrun_q;
    logic                bypass_q;
    logic [9:0]          sumR_q;
    logic [9:0]          sumG_q;
    logic [9:0]          sumB_q;
    logic [1:0]          capCnt_q;
    logic [READ_LAT-1:0] issueDly_q;
    logic [READ_LAT-1:0] issueDly_d;

    logic                capture;
    logic [9:0]          sumR_d;
    logic [9:0]          sumG_d;
    logic [9:0]          sumB_d;

    // Captures follow the issue strobe through a READ_LAT-deep shift line, so
    // alignment to returning data never depends on the FSM state.
    always_comb begin
        issueDly_d    = '0;
        issueDly_d[0] = (state_q == ISSUE);
        for (int i = 1; i < READ_LAT; i++) begin
            issueDly_d[i] = issueDly_q[i-1];
        end
    end

    assign capture = issueDly_q[READ_LAT-1];
    assign sumR_d  = sumR_q + {2'b00, bus.vramData[23:16]};
    assign sumG_d  = sumG_q + {2'b00, bus.vramData[15:8]};
    assign sumB_d  = sumB_q + {2'b00, bus.vramData[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addrCount_q  <= 3'd0;
            pixel_q      <= 24'h000000;
            tap0_q       <= 24'h000000;
            pixelValid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            bypass_q     <= 1'b0;
            sumR_q       <= 10'd0;
            sumG_q       <= 10'd0;
            sumB_q       <= 10'd0;
            capCnt_q     <= 2'd0;
            issueDly_q   <= '0;
        end else begin
            issueDly_q   <= issueDly_d;
            pixelValid_q <= 1'b0;

            if (capture) begin
                sumR_q   <= sumR_d;
                sumG_q   <= sumG_d;
                sumB_q   <= sumB_d;
                capCnt_q <= capCnt_q + 2'd1;
                if (capCnt_q == 2'd0) begin
                    tap0_q <= bus.vramData;
                end
            end

            case (state_q)
                IDLE, OUT: begin
                    if (bus.start) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        bypass_q    <= bus.bypass;
                        addrCount_q <= 3'd0;
                        sumR_q      <= 10'd0;
                        sumG_q      <= 10'd0;
                        sumB_q      <= 10'd0;
                        capCnt_q    <= 2'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                ISSUE: begin
                    if (bus.start) begin
                        overrun_q <= 1'b1;
                    end
                    if (addrCount_q == 3'd3) begin
                        state_q     <= DRAIN;
                        addrCount_q <= 3'd0;
                    end else begin
                        addrCount_q <= addrCount_q + 3'd1;
                    end
                end

                DRAIN: begin
                    if (bus.start) begin
                        overrun_q <= 1'b1;
                    end
                    // Tap D arriving this cycle completes the pixel; fold it in directly.
                    if (capture && capCnt_q == 2'd3) begin
                        state_q      <= OUT;
                        busy_q       <= 1'b0;
                        pixelValid_q <= 1'b1;
                        pixel_q      <= bypass_q ? tap0_q
                                                 : {sumR_d[9:2], sumG_d[9:2], sumB_d[9:2]};
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.addrCount  = addrCount_q;
    assign bus.pixel      = pixel_q;
    assign bus.pixelValid = pixelValid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pixel_gather.sv
// Drives READ_LAT=2 and READ_LAT=4 gatherers with identical stimulus and compares
// each against a cycle-indexed reference model built from request timing rules.
module tb_pixel_gather;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bypass = 1'b0;
    logic [23:0] vramData = 24'h0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [23:0] vramLog [0:8191];

    int          lastT   [NI];
    bit          lastByp [NI];
    bit          ovrExp  [NI];
    logic [23:0] pixExp  [NI];

    logic [2:0]  obsAddr  [NI];
    logic [23:0] obsPixel [NI];
    logic        obsValid [NI];
    logic        obsBusy  [NI];
    logic        obsOvr   [NI];

    always #5 clk = ~clk;

    pixel_gather_if busA ();
    pixel_gather_if busB ();

    assign busA.start    = start;
    assign busA.bypass   = bypass;
    assign busA.vramData = vramData;
    assign busB.start    = start;
    assign busB.bypass   = bypass;
    assign busB.vramData = vramData;

    pixel_gather #(.READ_LAT(2)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
    pixel_gather #(.READ_LAT(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

    assign obsAddr[0]  = busA.addrCount;
    assign obsPixel[0] = busA.pixel;
    assign obsValid[0] = busA.pixelValid;
    assign obsBusy[0]  = busA.busy;
    assign obsOvr[0]   = busA.overrun;
    assign obsAddr[1]  = busB.addrCount;
    assign obsPixel[1] = busB.pixel;
    assign obsValid[1] = busB.pixelValid;
    assign obsBusy[1]  = busB.busy;
    assign obsOvr[1]   = busB.overrun;

    function automatic int latOf(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Tap k of a request accepted at cycle T is on the bus during cycle T+1+k+L.
    function automatic logic [23:0] computePixel(input int i);
        int          l;
        int          r;
        int          g;
        int          b;
        logic [23:0] t;
        l = latOf(i);
        r = 0;
        g = 0;
        b = 0;
        for (int k = 0; k < 4; k++) begin
            t = vramLog[lastT[i] + 1 + k + l];
            r += int'(t[23:16]);
            g += int'(t[15:8]);
            b += int'(t[7:0]);
        end
        if (lastByp[i]) begin
            return vramLog[lastT[i] + 1 + l];
        end
        return {8'(r / 4), 8'(g / 4), 8'(b / 4)};
    endfunction

    task automatic checkAll();
        int   l;
        int   d;
        logic [2:0] expAddr;
        logic expBusy;
        logic expValid;
        for (int i = 0; i < NI; i++) begin
            l        = latOf(i);
            expAddr  = 3'd0;
            expBusy  = 1'b0;
            expValid = 1'b0;
            if (lastT[i] >= 0) begin
                d = cyc - lastT[i];
                if (d >= 1 && d <= 4) expAddr = 3'(d - 1);
                if (d >= 1 && d <= 4 + l) expBusy = 1'b1;
                if (d == 5 + l) begin
                    expValid  = 1'b1;
                    pixExp[i] = computePixel(i);
                end
            end
            checkOutput($sformatf("L%0d addr@%0d", l, cyc), 32'(obsAddr[i]), 32'(expAddr));
            checkOutput($sformatf("L%0d busy@%0d", l, cyc), 32'(obsBusy[i]), 32'(expBusy));
            checkOutput($sformatf("L%0d valid@%0d", l, cyc), 32'(obsValid[i]), 32'(expValid));
            checkOutput($sformatf("L%0d pixel@%0d", l, cyc), 32'(obsPixel[i]), 32'(pixExp[i]));
            checkOutput($sformatf("L%0d overrun@%0d", l, cyc), 32'(obsOvr[i]), 32'(ovrExp[i]));
        end
    endtask

    task automatic applyStimulus(input bit s, input bit b, input logic [23:0] d, input bit r);
        @(posedge clk);
        cyc++;
        #1;
        rst_n    = r;
        start    = s;
        bypass   = b;
        vramData = d;
        vramLog[cyc] = d;
        if (!r) begin
            for (int i = 0; i < NI; i++) begin
                lastT[i]  = -1;
                ovrExp[i] = 1'b0;
                pixExp[i] = 24'h0;
            end
        end
        @(negedge clk);
        checkAll();
        if (s && r) begin
            for (int i = 0; i < NI; i++) begin
                if (lastT[i] < 0 || cyc - lastT[i] >= 5 + latOf(i)) begin
                    lastT[i]   = cyc;
                    lastByp[i] = b;
                end else begin
                    ovrExp[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(1'b0, 1'b0, 24'($urandom), 1'b1);
    endtask

    // Places the four taps where the READ_LAT=2 instance will capture them.
    task automatic runTaps(input bit byp, input logic [23:0] taps [4], input logic [23:0] want);
        logic [23:0] d;
        applyStimulus(1'b1, byp, 24'($urandom), 1'b1);
        for (int j = 1; j <= 7; j++) begin
            d = (j >= 3 && j <= 6) ? taps[j-3] : 24'($urandom);
            applyStimulus(1'b0, 1'($urandom), d, 1'b1);
            if (j >= 1 && j <= 4) checkOutput("dir addr", 32'(busA.addrCount), 32'(j - 1));
        end
        checkOutput("dir valid", 32'(busA.pixelValid), 32'd1);
        checkOutput("dir pixel", 32'(busA.pixel), 32'(want));
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            lastT[i]   = -1;
            lastByp[i] = 1'b0;
            ovrExp[i]  = 1'b0;
            pixExp[i]  = 24'h0;
        end

        for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 24'($urandom), 1'b0);
        idle(2);

        runTaps(1'b0, '{24'h102030, 24'h302010, 24'h000000, 24'h040404}, 24'h111111);
        runTaps(1'b0, '{24'hFFFF01, 24'hFFFF01, 24'hFFFF01, 24'hFFFF00}, 24'hFFFF00);
        runTaps(1'b0, '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 24'hFFFFFF);
        runTaps(1'b1, '{24'hABCDEF, 24'h000000, 24'h000000, 24'h000000}, 24'hABCDEF);

        // Overrun while busy, then a back-to-back start during the output cycle.
        for (int j = 0; j <= 16; j++) begin
            applyStimulus(j == 0 || j == 3 || j == 7, 1'b0, 24'($urandom), 1'b1);
            if (j == 4)  checkOutput("ovr set", 32'(busA.overrun), 32'd1);
            if (j == 7)  checkOutput("first strobe", 32'(busA.pixelValid), 32'd1);
            if (j == 8)  checkOutput("b2b addr", 32'(busA.addrCount), 32'd0);
            if (j == 8)  checkOutput("b2b busy", 32'(busA.busy), 32'd1);
            if (j == 14) checkOutput("second strobe", 32'(busA.pixelValid), 32'd1);
        end
        idle(3);

        // Reset in the middle of a fetch, then restart on release.
        applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b1);
        idle(3);
        applyStimulus(1'b0, 1'b0, 24'($urandom), 1'b0);
        checkOutput("rst pixel", 32'(busA.pixel), 32'd0);
        checkOutput("rst overrun", 32'(busA.overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 24'($urandom), 1'b0);
        applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b1);
        for (int j = 1; j <= 7; j++) applyStimulus(1'b0, 1'b0, 24'($urandom), 1'b1);
        checkOutput("post-rst strobe", 32'(busA.pixelValid), 32'd1);
        idle(3);

        for (int j = 0; j < 400; j++) begin
            applyStimulus($urandom_range(0, 3) == 0, 1'($urandom), 24'($urandom),
                          $urandom_range(0, 199) != 0);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
